conv_engine_ctrl: RTL



---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_engine_ctrl_if.sv | 33 +++
 rtl/conv_mac.sv | 46 ++++
 rtl/conv_engine_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution engine sequencer.
//   - FSM state encodings (3 bits, plain localparams so older tools can use them)
//   - default image/kernel geometry, also used by the top-level controller
//     and the RAM wrappers
//   - clog2_min1: clog2 that never returns 0, used to size counters and addresses
package conv_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int CONV_IMG_W = 8;
  localparam int CONV_IMG_H = 8;
  localparam int CONV_K     = 3;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/conv_engine_ctrl_if.sv
// conv_engine_ctrl_if: RAM-side bus of the convolution sequencer.
// Ports / members:
//   ifmd_rd_addr/ifmd_rd_data : IFMD RAM read (data signed, 1-cycle latency)
//   kern_rd_addr/kern_rd_data : kernel RAM read (data signed, 1-cycle latency)
//   ofmd_wr_en/addr/data      : OFMD RAM write
// Modports: master = sequencer, slave = RAM wrappers.
interface conv_engine_ctrl_if #(
  parameter int IF_AW  = 6,
  parameter int KN_AW  = 4,
  parameter int OF_AW  = 6,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
);

  logic [IF_AW-1:0]  ifmd_rd_addr;
  logic [DATA_W-1:0] ifmd_rd_data;
  logic [KN_AW-1:0]  kern_rd_addr;
  logic [DATA_W-1:0] kern_rd_data;
  logic              ofmd_wr_en;
  logic [OF_AW-1:0]  ofmd_wr_addr;
  logic [ACC_W-1:0]  ofmd_wr_data;

  modport master (
    output ifmd_rd_addr, kern_rd_addr, ofmd_wr_en, ofmd_wr_addr, ofmd_wr_data,
    input  ifmd_rd_data, kern_rd_data
  );

  modport slave (
    input  ifmd_rd_addr, kern_rd_addr, ofmd_wr_en, ofmd_wr_addr, ofmd_wr_data,
    output ifmd_rd_data, kern_rd_data
  );

endinterface

// File: rtl/conv_mac.sv
// conv_mac: signed DATA_W x DATA_W multiply, sign-extended into a wrapping
// ACC_W accumulator.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : clear accumulator (wins over acc_en)
//   acc_en     : add a*b to accumulator
//   a, b       : signed operands
//   acc        : accumulator value
module conv_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] a_ext, b_ext, prod;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    acc_d, acc_q;

  // Sign-extending both operands to the product width lets a plain
  // (unsigned) multiply produce the correct two's-complement product.
  assign a_ext    = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_ext    = {{DATA_W{b[DATA_W-1]}}, b};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (clr)         acc_d = '0;
    else if (acc_en) acc_d = acc_q + prod_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv_engine_ctrl.sv
// conv_engine_ctrl: convolution engine sequencer. On conv_start it walks every
// valid (stride 1, no padding) output position, reads the KxK window and the
// kernel, accumulates, writes one OFMD word per position, then raises conv_done
// until conv_start falls.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   conv_start  : level request from the top-level controller
//   conv_done   : map complete, held while conv_start stays high
//   bus         : conv_engine_ctrl_if.master (IFMD/kernel reads, OFMD write)
// Build option: CONV_RELU_EN clamps negative results to 0 on write.
//
// state | meaning
// IDLE  | waiting for conv_start, all outputs 0
// FETCH | issue one tap per cycle, accumulate previous tap
// DRAIN | accumulate last tap
// WRITE | one-cycle OFMD write, advance output position
// DONE  | conv_done high until conv_start drops
module conv_engine_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W  = CONV_IMG_W,
  parameter int IMG_H  = CONV_IMG_H,
  parameter int K      = CONV_K,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic conv_start,
  output logic conv_done,
  conv_engine_ctrl_if.master bus
);

  localparam int OW    = IMG_W - K + 1;
  localparam int OH    = IMG_H - K + 1;
  localparam int IF_AW = clog2_min1(IMG_W * IMG_H);
  localparam int KN_AW = clog2_min1(K * K);
  localparam int OF_AW = clog2_min1(OW * OH);
  localparam int XW    = clog2_min1(K);
  localparam int OXW   = clog2_min1(OW);
  localparam int OYW   = clog2_min1(OH);

  logic [2:0]     state_d, state_q;
  logic [XW-1:0]  kx_d, kx_q, ky_d, ky_q;
  logic [OXW-1:0] ox_d, ox_q;
  logic [OYW-1:0] oy_d, oy_q;
  logic           mac_clr, mac_en;
  logic           last_pix;
  logic [ACC_W-1:0] acc;

  assign last_pix = (ox_q == OXW'(OW-1)) && (oy_q == OYW'(OH-1));

  always_comb begin
    state_d = state_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (conv_start) begin
          state_d = ST_FETCH;
          kx_d    = '0;
          ky_d    = '0;
          ox_d    = '0;
          oy_d    = '0;
          mac_clr = 1'b1;
        end
      end
      ST_FETCH: begin
        // Data for the tap issued last cycle is on the read bus now; tap 0
        // has no predecessor within this pixel.
        mac_en = (kx_q != '0) || (ky_q != '0);
        if (kx_q == XW'(K-1)) begin
          kx_d = '0;
          if (ky_q == XW'(K-1)) begin
            ky_d    = '0;
            state_d = ST_DRAIN;
          end else begin
            ky_d = ky_q + XW'(1);
          end
        end else begin
          kx_d = kx_q + XW'(1);
        end
      end
      ST_DRAIN: begin
        mac_en  = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        mac_clr = 1'b1;
        if (last_pix) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FETCH;
          if (ox_q == OXW'(OW-1)) begin
            ox_d = '0;
            oy_d = oy_q + OYW'(1);
          end else begin
            ox_d = ox_q + OXW'(1);
          end
        end
      end
      ST_DONE: begin
        if (!conv_start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      kx_q    <= '0;
      ky_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
    end else begin
      state_q <= state_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
    end
  end

  conv_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (mac_clr),
    .acc_en (mac_en),
    .a      (bus.ifmd_rd_data),
    .b      (bus.kern_rd_data),
    .acc    (acc)
  );

  // Addresses are decoded straight from the tap/position flops, so they are
  // stable for the whole cycle and the RAM returns data on the next one.
  assign bus.ifmd_rd_addr = (state_q == ST_FETCH)
      ? (IF_AW'(oy_q) + IF_AW'(ky_q)) * IF_AW'(IMG_W) + IF_AW'(ox_q) + IF_AW'(kx_q)
      : '0;
  assign bus.kern_rd_addr = (state_q == ST_FETCH)
      ? KN_AW'(ky_q) * KN_AW'(K) + KN_AW'(kx_q)
      : '0;

  assign bus.ofmd_wr_en   = (state_q == ST_WRITE);
  assign bus.ofmd_wr_addr = (state_q == ST_WRITE)
      ? OF_AW'(oy_q) * OF_AW'(OW) + OF_AW'(ox_q)
      : '0;
`ifdef CONV_RELU_EN
  assign bus.ofmd_wr_data = (state_q == ST_WRITE && !acc[ACC_W-1]) ? acc : '0;
`else
  assign bus.ofmd_wr_data = (state_q == ST_WRITE) ? acc : '0;
`endif

  assign conv_done = (state_q == ST_DONE);

endmodule
